// File: rtl/axi_lite_arbiter_rr.sv
// axi_lite_arbiter_rr: N-master to 1-slave AXI-lite arbiter with round-robin grant.
// Only one read or write transaction is in flight at a time. The grant is held
// until the R or B handshake completes. All channels are muxed combinationally
// from the registered grant and state, so nothing is buffered.
// Optional macro ARB_FIXED_PRIO_EN: when defined, the lowest-index requester
// always wins and the round-robin pointer is removed.
module axi_lite_arbiter_rr #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int STRB_W      = DATA_W / 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_araddr,
    input  logic [NUM_MASTERS-1:0]        m_arvalid,
    output logic [NUM_MASTERS-1:0]        m_arready,
    output logic [NUM_MASTERS*DATA_W-1:0] m_rdata,
    output logic [NUM_MASTERS*2-1:0]      m_rresp,
    output logic [NUM_MASTERS-1:0]        m_rvalid,
    input  logic [NUM_MASTERS-1:0]        m_rready,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_awaddr,
    input  logic [NUM_MASTERS-1:0]        m_awvalid,
    output logic [NUM_MASTERS-1:0]        m_awready,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
    input  logic [NUM_MASTERS*STRB_W-1:0] m_wstrb,
    input  logic [NUM_MASTERS-1:0]        m_wvalid,
    output logic [NUM_MASTERS-1:0]        m_wready,
    output logic [NUM_MASTERS*2-1:0]      m_bresp,
    output logic [NUM_MASTERS-1:0]        m_bvalid,
    input  logic [NUM_MASTERS-1:0]        m_bready,
    output logic [ADDR_W-1:0]             s_araddr,
    output logic                          s_arvalid,
    input  logic                          s_arready,
    input  logic [DATA_W-1:0]             s_rdata,
    input  logic [1:0]                    s_rresp,
    input  logic                          s_rvalid,
    output logic                          s_rready,
    output logic [ADDR_W-1:0]             s_awaddr,
    output logic                          s_awvalid,
    input  logic                          s_awready,
    output logic [DATA_W-1:0]             s_wdata,
    output logic [STRB_W-1:0]             s_wstrb,
    output logic                          s_wvalid,
    input  logic                          s_wready,
    input  logic [1:0]                    s_bresp,
    input  logic                          s_bvalid,
    output logic                          s_bready
);

    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_MASTERS - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP
    } state_t;

    state_t                  fsm, fsm_next;
    logic [IDX_W-1:0]        gnt, gnt_next, pick;
    logic                    aw_done, aw_done_next;
    logic                    w_done, w_done_next;
    logic                    found;
    logic [NUM_MASTERS-1:0]  req;
`ifndef ARB_FIXED_PRIO_EN
    logic [IDX_W-1:0]        ptr, ptr_next, gnt_inc;
    int                      idx;
`endif

    assign req = m_arvalid | m_awvalid;

`ifndef ARB_FIXED_PRIO_EN
    // The master after the current grant, wrapping; this becomes the new search start.
    assign gnt_inc = (gnt == LAST) ? '0 : gnt + 1'b1;
`endif

    // Pick the winning requester: the first set req bit from ptr upward, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = '0;
`ifdef ARB_FIXED_PRIO_EN
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (!found && req[k]) begin
                found = 1'b1;
                pick  = IDX_W'(k);
            end
        end
`else
        idx = 0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = IDX_W'(idx);
            end
        end
`endif
    end

    // Next-state logic: arbitration in IDLE, then follow the granted transaction's handshakes.
    always_comb begin
        fsm_next     = fsm;
        gnt_next     = gnt;
        aw_done_next = aw_done;
        w_done_next  = w_done;
`ifndef ARB_FIXED_PRIO_EN
        ptr_next     = ptr;
`endif
        case (fsm)
            IDLE: begin
                if (found) begin
                    gnt_next = pick;
                    fsm_next = m_awvalid[pick] ? WR_REQ : RD_ADDR;
                end
            end
            RD_ADDR: begin
                if (s_arvalid && s_arready) fsm_next = RD_DATA;
            end
            RD_DATA: begin
                if (s_rvalid && s_rready) begin
`ifndef ARB_FIXED_PRIO_EN
                    ptr_next = gnt_inc;
`endif
                    fsm_next = IDLE;
                end
            end
            WR_REQ: begin
                aw_done_next = aw_done | (s_awvalid & s_awready);
                w_done_next  = w_done | (s_wvalid & s_wready);
                if (aw_done_next && w_done_next) begin
                    fsm_next     = WR_RESP;
                    aw_done_next = 1'b0;
                    w_done_next  = 1'b0;
                end
            end
            WR_RESP: begin
                if (s_bvalid && s_bready) begin
`ifndef ARB_FIXED_PRIO_EN
                    ptr_next = gnt_inc;
`endif
                    fsm_next = IDLE;
                end
            end
            default: fsm_next = IDLE;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm     <= IDLE;
            gnt     <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
            ptr     <= '0;
`endif
        end else begin
            fsm     <= fsm_next;
            gnt     <= gnt_next;
            aw_done <= aw_done_next;
            w_done  <= w_done_next;
`ifndef ARB_FIXED_PRIO_EN
            ptr     <= ptr_next;
`endif
        end
    end

    // Channel muxing: only the granted master's active channel is connected, everything else is 0.
    always_comb begin
        m_arready = '0;
        m_rdata   = '0;
        m_rresp   = '0;
        m_rvalid  = '0;
        m_awready = '0;
        m_wready  = '0;
        m_bresp   = '0;
        m_bvalid  = '0;
        s_araddr  = '0;
        s_arvalid = 1'b0;
        s_rready  = 1'b0;
        s_awaddr  = '0;
        s_awvalid = 1'b0;
        s_wdata   = '0;
        s_wstrb   = '0;
        s_wvalid  = 1'b0;
        s_bready  = 1'b0;
        case (fsm)
            RD_ADDR: begin
                s_araddr       = m_araddr[int'(gnt)*ADDR_W +: ADDR_W];
                s_arvalid      = m_arvalid[gnt];
                m_arready[gnt] = s_arready;
            end
            RD_DATA: begin
                m_rvalid[gnt]                      = s_rvalid;
                m_rdata[int'(gnt)*DATA_W +: DATA_W] = s_rdata;
                m_rresp[int'(gnt)*2 +: 2]           = s_rresp;
                s_rready                           = m_rready[gnt];
            end
            WR_REQ: begin
                s_awaddr       = m_awaddr[int'(gnt)*ADDR_W +: ADDR_W];
                s_awvalid      = m_awvalid[gnt] & ~aw_done;
                m_awready[gnt] = s_awready & ~aw_done;
                s_wdata        = m_wdata[int'(gnt)*DATA_W +: DATA_W];
                s_wstrb        = m_wstrb[int'(gnt)*STRB_W +: STRB_W];
                s_wvalid       = m_wvalid[gnt] & ~w_done;
                m_wready[gnt]  = s_wready & ~w_done;
            end
            WR_RESP: begin
                m_bvalid[gnt]             = s_bvalid;
                m_bresp[int'(gnt)*2 +: 2] = s_bresp;
                s_bready                  = m_bready[gnt];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axi_lite_arbiter_rr.sv
// tb_axi_lite_arbiter_rr: directed self-checking bench for axi_lite_arbiter_rr
// with three masters. The slave side is driven by hand from the stimulus sequence.
// Honours ARB_FIXED_PRIO_EN for the expected grant order.
module tb_axi_lite_arbiter_rr;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [N*AW-1:0]   m_araddr;
    logic [N-1:0]      m_arvalid;
    logic [N-1:0]      m_arready;
    logic [N*DW-1:0]   m_rdata;
    logic [N*2-1:0]    m_rresp;
    logic [N-1:0]      m_rvalid;
    logic [N-1:0]      m_rready;
    logic [N*AW-1:0]   m_awaddr;
    logic [N-1:0]      m_awvalid;
    logic [N-1:0]      m_awready;
    logic [N*DW-1:0]   m_wdata;
    logic [N*SW-1:0]   m_wstrb;
    logic [N-1:0]      m_wvalid;
    logic [N-1:0]      m_wready;
    logic [N*2-1:0]    m_bresp;
    logic [N-1:0]      m_bvalid;
    logic [N-1:0]      m_bready;
    logic [AW-1:0]     s_araddr;
    logic              s_arvalid;
    logic              s_arready;
    logic [DW-1:0]     s_rdata;
    logic [1:0]        s_rresp;
    logic              s_rvalid;
    logic              s_rready;
    logic [AW-1:0]     s_awaddr;
    logic              s_awvalid;
    logic              s_awready;
    logic [DW-1:0]     s_wdata;
    logic [SW-1:0]     s_wstrb;
    logic              s_wvalid;
    logic              s_wready;
    logic [1:0]        s_bresp;
    logic              s_bvalid;
    logic              s_bready;

    int checks   = 0;
    int failures = 0;
    logic [N-1:0] exp_rr [4];

    axi_lite_arbiter_rr #(
        .NUM_MASTERS(N),
        .ADDR_W(AW),
        .DATA_W(DW),
        .STRB_W(SW)
    ) dut (
        .clk(clk), .rst(rst),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    // Advance a number of rising edges and stop 1 unit after the last one.
    task automatic applyStimulus(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    // One immediate-assertion comparison.
    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Zero every input driven into the DUT (except the reset).
    task automatic clearInputs();
        m_araddr  = '0; m_arvalid = '0; m_rready = '0;
        m_awaddr  = '0; m_awvalid = '0; m_wdata  = '0;
        m_wstrb   = '0; m_wvalid  = '0; m_bready = '0;
        s_arready = 1'b0; s_rdata = '0; s_rresp = '0; s_rvalid = 1'b0;
        s_awready = 1'b0; s_wready = 1'b0; s_bresp = '0; s_bvalid = 1'b0;
    endtask

    // Two-cycle reset, leaving all inputs cleared.
    task automatic doReset();
        clearInputs();
        rst = 1'b1;
        applyStimulus(2);
        rst = 1'b0;
    endtask

    // Directed sequence.
    initial begin
`ifdef ARB_FIXED_PRIO_EN
        exp_rr[0] = 3'b001; exp_rr[1] = 3'b001; exp_rr[2] = 3'b001; exp_rr[3] = 3'b001;
`else
        exp_rr[0] = 3'b001; exp_rr[1] = 3'b010; exp_rr[2] = 3'b100; exp_rr[3] = 3'b001;
`endif
        $display("[TB] start");

        // Reset with noisy inputs: every output must be quiet.
        clearInputs();
        rst = 1'b1;
        m_arvalid = 3'b111; m_rready = 3'b111; m_bready = 3'b111;
        s_rvalid = 1'b1; s_bvalid = 1'b1; s_rdata = 32'hFFFF_FFFF; s_rresp = 2'b11;
        s_arready = 1'b1; s_awready = 1'b1; s_wready = 1'b1;
        applyStimulus(2);
        checkOutput("rst_m_arready", m_arready, 0);
        checkOutput("rst_m_rvalid", m_rvalid, 0);
        checkOutput("rst_m_rdata", m_rdata, 0);
        checkOutput("rst_m_rresp", m_rresp, 0);
        checkOutput("rst_m_bvalid", m_bvalid, 0);
        checkOutput("rst_s_arvalid", s_arvalid, 0);
        checkOutput("rst_s_rready", s_rready, 0);
        checkOutput("rst_s_bready", s_bready, 0);
        doReset();

        // Single read from master1.
        m_arvalid = 3'b010;
        m_araddr[1*AW +: AW] = 32'h8000_0010;
        s_arready = 1'b1;
        #1;
        checkOutput("rd_latency_s_arvalid", s_arvalid, 0);
        applyStimulus(1);
        checkOutput("rd_s_arvalid", s_arvalid, 1);
        checkOutput("rd_s_araddr", s_araddr, 32'h8000_0010);
        checkOutput("rd_m_arready", m_arready, 3'b010);
        applyStimulus(1);
        m_arvalid = '0;
        m_rready  = 3'b010;
        #1;
        checkOutput("rd_wait_m_rvalid", m_rvalid, 0);
        checkOutput("rd_wait_s_rready", s_rready, 1);
        applyStimulus(2);
        s_rvalid = 1'b1; s_rdata = 32'hDEAD_BEEF; s_rresp = 2'b00;
        #1;
        checkOutput("rd_m_rvalid", m_rvalid, 3'b010);
        checkOutput("rd_m_rdata", m_rdata, 96'h0000_0000_DEAD_BEEF_0000_0000);
        applyStimulus(1);
        clearInputs();
        #1;
        checkOutput("rd_done_m_rvalid", m_rvalid, 0);

        // Write from master0 with W arriving three cycles after AW.
        m_awvalid = 3'b001;
        m_awaddr[0 +: AW] = 32'h8000_0100;
        s_awready = 1'b1; s_wready = 1'b1;
        applyStimulus(1);
        checkOutput("wr_s_awvalid", s_awvalid, 1);
        checkOutput("wr_s_awaddr", s_awaddr, 32'h8000_0100);
        checkOutput("wr_s_wvalid_early", s_wvalid, 0);
        checkOutput("wr_m_awready", m_awready, 3'b001);
        applyStimulus(1);
        checkOutput("wr_aw_gated_s_awvalid", s_awvalid, 0);
        checkOutput("wr_aw_gated_m_awready", m_awready, 0);
        checkOutput("wr_no_read_s_arvalid", s_arvalid, 0);
        applyStimulus(1);
        m_awvalid = '0;
        m_wvalid  = 3'b001;
        m_wdata[0 +: DW] = 32'h1234_5678;
        m_wstrb[0 +: SW] = 4'hF;
        #1;
        checkOutput("wr_s_wvalid", s_wvalid, 1);
        checkOutput("wr_s_wdata", s_wdata, 32'h1234_5678);
        checkOutput("wr_s_wstrb", s_wstrb, 4'hF);
        checkOutput("wr_m_wready", m_wready, 3'b001);
        applyStimulus(1);
        m_wvalid = '0;
        s_bvalid = 1'b1; s_bresp = 2'b10; m_bready = 3'b001;
        #1;
        checkOutput("wr_m_bvalid", m_bvalid, 3'b001);
        checkOutput("wr_m_bresp", m_bresp, 6'b00_00_10);
        checkOutput("wr_s_bready", s_bready, 1);
        checkOutput("wr_s_wvalid_after", s_wvalid, 0);
        applyStimulus(1);
        clearInputs();

        // Round-robin with three masters reading continuously.
        doReset();
        m_arvalid = 3'b111; m_rready = 3'b111;
        s_arready = 1'b1; s_rvalid = 1'b1; s_rdata = 32'hA5A5_0000;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1);
            checkOutput($sformatf("rr_grant%0d_m_arready", i), m_arready, exp_rr[i]);
            applyStimulus(1);
            checkOutput($sformatf("rr_grant%0d_m_rvalid", i), m_rvalid, exp_rr[i]);
            applyStimulus(1);
        end
        clearInputs();

        // Master2 asks for read and write together: the write goes first.
        m_arvalid = 3'b100; m_awvalid = 3'b100; m_wvalid = 3'b100;
        m_araddr[2*AW +: AW] = 32'h0000_0100;
        m_awaddr[2*AW +: AW] = 32'h0000_0200;
        m_wdata[2*DW +: DW]  = 32'h0BAD_F00D;
        m_wstrb[2*SW +: SW]  = 4'h3;
        s_arready = 1'b1; s_awready = 1'b1; s_wready = 1'b1;
        applyStimulus(1);
        checkOutput("rw_s_awvalid", s_awvalid, 1);
        checkOutput("rw_s_wvalid", s_wvalid, 1);
        checkOutput("rw_s_arvalid", s_arvalid, 0);
        checkOutput("rw_m_awready", m_awready, 3'b100);
        applyStimulus(1);
        m_awvalid = '0; m_wvalid = '0;
        s_bvalid = 1'b1; m_bready = 3'b100;
        #1;
        checkOutput("rw_m_bvalid", m_bvalid, 3'b100);
        applyStimulus(1);
        s_bvalid = 1'b0; m_bready = '0;
        #1;
        checkOutput("rw_idle_s_arvalid", s_arvalid, 0);
        applyStimulus(1);
        checkOutput("rw_read_s_arvalid", s_arvalid, 1);
        checkOutput("rw_read_s_araddr", s_araddr, 32'h0000_0100);
        checkOutput("rw_read_m_arready", m_arready, 3'b100);
        applyStimulus(1);
        m_arvalid = '0;
        s_rvalid = 1'b1; s_rdata = 32'hCAFE_F00D; s_rresp = 2'b01; m_rready = 3'b100;
        #1;
        checkOutput("rw_read_m_rdata", m_rdata, 96'hCAFE_F00D_0000_0000_0000_0000);
        checkOutput("rw_read_m_rresp", m_rresp, 6'b01_00_00);
        applyStimulus(1);
        clearInputs();

        // Master0 read held by R backpressure while master1 waits.
        m_arvalid = 3'b011;
        s_arready = 1'b1;
        applyStimulus(1);
        checkOutput("bp_m_arready", m_arready, 3'b001);
        applyStimulus(1);
        m_arvalid = 3'b010;
        s_rvalid = 1'b1; s_rdata = 32'h0000_0055; m_rready = '0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checkOutput($sformatf("bp_hold%0d_s_rready", i), s_rready, 0);
            checkOutput($sformatf("bp_hold%0d_m_rvalid", i), m_rvalid, 3'b001);
            checkOutput($sformatf("bp_hold%0d_m_arready", i), m_arready, 0);
            applyStimulus(1);
        end
        m_rready = 3'b001;
        #1;
        checkOutput("bp_release_s_rready", s_rready, 1);
        applyStimulus(1);
        s_rvalid = 1'b0; m_rready = '0;
        #1;
        checkOutput("bp_idle_m_arready", m_arready, 0);
        applyStimulus(1);
        checkOutput("bp_next_m_arready", m_arready, 3'b010);
        applyStimulus(1);
        m_arvalid = '0;
        s_rvalid = 1'b1; m_rready = 3'b010;
        applyStimulus(1);
        clearInputs();

        // Reset while master1 sits in the write response phase.
        m_awvalid = 3'b010; m_wvalid = 3'b010;
        s_awready = 1'b1; s_wready = 1'b1;
        applyStimulus(2);
        m_awvalid = '0; m_wvalid = '0;
        s_bvalid = 1'b1; m_bready = 3'b010;
        #1;
        checkOutput("rstwr_m_bvalid", m_bvalid, 3'b010);
        rst = 1'b1;
        applyStimulus(1);
        checkOutput("rstwr_m_bvalid_after", m_bvalid, 0);
        checkOutput("rstwr_s_bready_after", s_bready, 0);
        checkOutput("rstwr_s_awvalid_after", s_awvalid, 0);
        rst = 1'b0;
        s_bvalid = 1'b0; m_bready = '0;
        m_arvalid = 3'b101; s_arready = 1'b1;
        #1;
        checkOutput("rstwr_idle_s_arvalid", s_arvalid, 0);
        applyStimulus(1);
        checkOutput("rstwr_ptr0_m_arready", m_arready, 3'b001);
        checkOutput("rstwr_ptr0_s_arvalid", s_arvalid, 1);
        doReset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
